// File: rtl/mod_updown_counter.sv
// ============================================================================
// Module   : mod_updown_counter
// Summary  : Prescaled up/down counter, runtime upper bound, wrap or saturate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             w_tick;
  logic             w_step;
  logic             w_bound;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_load_val;

  generate
    if (PRESCALE > 1) begin : g_presc
      localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);
      logic [c_PW-1:0] r_pcnt;

      // Load and reset both discard a partial prescale count.
      always_ff @(posedge clk) begin
        if (rst || load) begin
          r_pcnt <= '0;
        end else if (en) begin
          if (r_pcnt == c_PMAX) r_pcnt <= '0;
          else                  r_pcnt <= r_pcnt + 1'b1;
        end
      end

      assign w_tick = (r_pcnt == c_PMAX);
    end else begin : g_nopresc
      assign w_tick = 1'b1;
    end
  endgenerate

  assign w_step     = en & ~load & w_tick;
  assign w_load_val = (din > limit) ? limit : din;

  // q above limit (limit lowered at runtime) is pulled back silently on a
  // down step, but counts as a bound event on an up step.
  always_comb begin
    w_q_step = r_q;
    w_bound  = 1'b0;
    if (up) begin
      if (r_q < limit) begin
        w_q_step = r_q + 1'b1;
      end else begin
        w_bound  = 1'b1;
        w_q_step = (SATURATE != 0) ? limit : '0;
      end
    end else if (r_q > limit) begin
      w_q_step = limit;
    end else if (r_q == '0) begin
      w_bound  = 1'b1;
      w_q_step = (SATURATE != 0) ? '0 : limit;
    end else begin
      w_q_step = r_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_q   <= w_load_val;
      r_ovf <= 1'b0;
    end else if (w_step) begin
      r_q   <= w_q_step;
      r_ovf <= w_bound;
    end else begin
      r_ovf <= 1'b0;
    end
  end

  assign q       = r_q;
  assign ovf     = r_ovf;
  assign at_max  = (r_q == limit);
  assign at_zero = (r_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// Module   : tb_mod_updown_counter
// Summary  : Three counter flavours on shared stimulus against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] limit = 4'd9;

  logic [3:0] q_o   [3];
  logic       ovf_o [3];
  logic       max_o [3];
  logic       zero_o[3];

  int total = 0;
  int bad   = 0;

  // Flavour table: 0 = wrap/prescale 1, 1 = saturate/prescale 1, 2 = wrap/prescale 3
  int ps  [3] = '{1, 1, 3};
  int sat [3] = '{0, 1, 0};
  int mq  [3];
  int mp  [3];
  int mo  [3];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .limit(limit),
    .q(q_o[0]), .ovf(ovf_o[0]), .at_max(max_o[0]), .at_zero(zero_o[0]));

  mod_updown_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .limit(limit),
    .q(q_o[1]), .ovf(ovf_o[1]), .at_max(max_o[1]), .at_zero(zero_o[1]));

  mod_updown_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) u_ps3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .limit(limit),
    .q(q_o[2]), .ovf(ovf_o[2]), .at_max(max_o[2]), .at_zero(zero_o[2]));

  // Reference: one clock edge worth of the counting rules, in plain integers.
  task automatic model_edge();
    int lim = int'(limit);
    for (int k = 0; k < 3; k++) begin
      mo[k] = 0;
      if (rst) begin
        mq[k] = 0; mp[k] = 0;
      end else if (load) begin
        mq[k] = (int'(din) < lim) ? int'(din) : lim;
        mp[k] = 0;
      end else if (en) begin
        mp[k] = mp[k] + 1;
        if (mp[k] == ps[k]) begin
          mp[k] = 0;
          if (up) begin
            if (mq[k] < lim) mq[k] = mq[k] + 1;
            else begin mq[k] = sat[k] ? lim : 0; mo[k] = 1; end
          end else begin
            if (mq[k] > lim) mq[k] = lim;
            else if (mq[k] == 0) begin mq[k] = sat[k] ? 0 : lim; mo[k] = 1; end
            else mq[k] = mq[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("q[%0d]", k),    q_o[k],           4'(mq[k]));
      chk($sformatf("ovf[%0d]", k),  {3'b0, ovf_o[k]}, 4'(mo[k]));
      chk($sformatf("max[%0d]", k),  {3'b0, max_o[k]}, {3'b0, (mq[k] == int'(limit))});
      chk($sformatf("zero[%0d]", k), {3'b0, zero_o[k]},{3'b0, (mq[k] == 0)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mp[k] = 0; mo[k] = 0; end

    // Reset with load and en also asserted: reset wins.
    rst = 1; load = 1; en = 1; din = 4'd5;
    tick();
    tick();
    load = 0; rst = 0;

    // Count up 0..9 and wrap, limit 9.
    up = 1; limit = 4'd9;
    repeat (14) tick();

    // Count down from zero.
    rst = 1; tick(); rst = 0;
    up = 0;
    repeat (5) tick();

    // Saturation at top from 14, limit 15.
    limit = 4'd15; load = 1; din = 4'd14; tick(); load = 0;
    up = 1;
    repeat (5) tick();

    // Prescaler with gaps: en 1,0,1,1 after reset.
    rst = 1; tick(); rst = 0;
    en = 1; tick();
    en = 0; tick();
    en = 1; tick();
    tick();
    en = 0; repeat (2) tick();

    // Load clamps to limit and suppresses the step; load together with reset.
    limit = 4'd9; en = 1; load = 1; din = 4'd12; tick();
    rst = 1; tick(); rst = 0; load = 0;

    // Limit lowered below q, then both directions.
    load = 1; din = 4'd7; tick(); load = 0;
    limit = 4'd5; up = 0; tick();
    load = 1; din = 4'd7; limit = 4'd9; tick(); load = 0;
    limit = 4'd5; up = 1; tick();

    // Zero limit: every step stays at 0 with overflow.
    limit = 4'd0; up = 1; repeat (4) tick();
    up = 0; repeat (4) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      load = ($urandom_range(0, 99) < 8);
      en   = ($urandom_range(0, 99) < 75);
      up   = $urandom_range(0, 1);
      din  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 10) limit = 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRESCALE, default 1, number of enabled cycles per count step (legal range 1..65535).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; the prescaler advances only while en=1.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step cycle.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 din  input  WIDTH  load value.
REQ-010 limit  input  WIDTH  runtime upper bound (inclusive); count range is 0..limit.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 ovf  output  1  registered one-cycle pulse flagging a wrap or saturation event.
REQ-013 at_max  output  1  combinational, q == limit.
REQ-014 at_zero  output  1  combinational, q == 0.

Function
REQ-015 Priority per rising edge SHALL be rst > load > step > hold.
REQ-016 An internal prescaler pcnt (0..PRESCALE-1) SHALL increment on each en=1 cycle without load; a step SHALL occur on the en=1 cycle where pcnt == PRESCALE-1, and pcnt SHALL return to 0 on that cycle.
REQ-017 With PRESCALE=1, a step SHALL occur on every en=1 cycle (pcnt constant 0).
REQ-018 en=0 SHALL freeze both q and pcnt.
REQ-019 load=1 SHALL set q to min(din, limit), clear pcnt to 0, and suppress any step on that cycle, regardless of en.
REQ-020 Up step, q < limit: q SHALL become q+1.
REQ-021 Up step, q >= limit: SATURATE=0 -> q SHALL become 0; SATURATE=1 -> q SHALL become limit; ovf SHALL pulse in both cases.
REQ-022 Down step, 0 < q <= limit: q SHALL become q-1.
REQ-023 Down step, q == 0: SATURATE=0 -> q SHALL become limit; SATURATE=1 -> q SHALL hold 0; ovf SHALL pulse in both cases.
REQ-024 Down step, q > limit (limit lowered at runtime): q SHALL become limit, and ovf SHALL NOT pulse.
REQ-025 ovf SHALL be 1 in exactly the cycle after a bound event per REQ-021/REQ-023, and 0 otherwise, including after load and hold cycles.
REQ-026 limit == 0: every step SHALL leave q at 0 and pulse ovf.
REQ-027 Arithmetic SHALL be modulo-free WIDTH-bit; no intermediate result SHALL exceed WIDTH bits when stored to q.
REQ-028 Changing up between steps SHALL take effect on the next step with no extra latency.

Reset
REQ-029 rst=1 on a rising edge SHALL set q=0, pcnt=0, ovf=0, overriding load and en.
REQ-030 Reset asserted mid-prescale SHALL discard the partial prescale count; the first step after release SHALL occur PRESCALE en=1 cycles later.
REQ-031 Outputs SHALL be defined (not X) from the first edge with rst=1.

Verification
REQ-032 WIDTH=4, PRESCALE=1, SATURATE=0, limit=9, up=1, en=1 from q=0 -> q runs 0..9,0 ; ovf=1 only in the cycle q first reads 0 after 9.
REQ-033 Same config, up=0 from q=0 -> next q=9, ovf pulse; then 8,7,...
REQ-034 SATURATE=1, limit=15, up=1 from q=14 -> q=15, then holds 15 with ovf pulsing once per step.
REQ-035 PRESCALE=3, en toggling 1,0,1,1 from reset -> q increments only after the third en=1 cycle (q=1), en=0 cycles change nothing.
REQ-036 load=1, din=12, limit=9, en=1 -> q=9, pcnt=0, no step or ovf that cycle; load and rst together -> q=0.
REQ-037 q=7, limit changed to 5, up=0 step -> q=5, ovf=0; up=1 step from q=7, limit=5 -> q=0, ovf=1.
